usb_cmd_decoder: RTL and testbench

Byte-stream command decoder on the USB FIFO receive path. Consumes one received byte per strobe from the USB FIFO interface stage, frames 1- or 2-byte commands, and issues register writes/reads to a 16-entry register space. Read and ping replies go into a one-byte hold register that the FIFO interface returns to the host on its next read.

---
 rtl/usb_cmd_pkg.sv | 20 ++
 rtl/usb_sat_counter.sv | 19 +
 rtl/usb_cmd_decoder.sv | 143 ++++++++++++++
 tb/tb_usb_cmd_decoder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/usb_cmd_pkg.sv
// Shared types for the USB FIFO command decoder: header op codes, framing
// constants and the decoder FSM state encoding.
package usb_cmd_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_PING  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  localparam int START_BIT = 7;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RDLAT
  } state_e;

endpackage

// File: rtl/usb_sat_counter.sv
// 8-bit counter that increments on inc and sticks at 8'hFF.
module usb_sat_counter (
  input  logic       CLK_USB,
  input  logic       RSTn,
  input  logic       inc,
  output logic [7:0] count
);

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge CLK_USB or negedge RSTn) begin
    if (!RSTn) begin
      count <= 8'h00;
    end else if (inc && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/usb_cmd_decoder.sv
// Frames 1- and 2-byte host commands from the USB FIFO receive stream into
// register read/write strobes and a one-byte reply hold register.
module usb_cmd_decoder
  import usb_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 4095,
  parameter int unsigned TIMER_W   = 12,
  parameter logic [7:0]  PING_BYTE = 8'hA5
) (
  input  logic       CLK_USB,
  input  logic       RSTn,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       reg_wr,
  output logic       reg_rd,
  output logic [3:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ack,
  output logic [7:0] err_count
);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               wr_d, rd_d;
  logic [3:0]         addr_d;
  logic [7:0]         wdata_d;
  logic               tx_load;
  logic [7:0]         tx_val;
  logic               hdr_take;
  logic               fsm_err;
  logic               ovw_err;
  op_e                hdr_op;
  logic [3:0]         hdr_addr;
  logic               unused_hdr_bit;

  assign hdr_op         = op_e'(rx_data[6:5]);
  assign hdr_addr       = rx_data[3:0];
  assign unused_hdr_bit = rx_data[4];

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
    addr_d   = reg_addr;
    wdata_d  = reg_wdata;
    tx_load  = 1'b0;
    tx_val   = tx_data;
    hdr_take = 1'b0;
    fsm_err  = 1'b0;

    case (state_q)
      IDLE: hdr_take = rx_valid;
      RDLAT: begin
        tx_load  = 1'b1;
        tx_val   = reg_rdata;
        state_d  = IDLE;
        hdr_take = rx_valid;
      end
      DATA: begin
        if (rx_valid) begin
          wr_d    = 1'b1;
          wdata_d = rx_data;
          state_d = IDLE;
        end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
          fsm_err = 1'b1;
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (hdr_take) begin
      if (!rx_data[START_BIT]) begin
        fsm_err = 1'b1;
      end else begin
        case (hdr_op)
          OP_WRITE: begin
            addr_d  = hdr_addr;
            timer_d = '0;
            state_d = DATA;
          end
          OP_READ: begin
            rd_d    = 1'b1;
            addr_d  = hdr_addr;
            state_d = RDLAT;
          end
          OP_PING: begin
            // A ping landing on the read-reply cycle replaces that reply.
            if (tx_load) fsm_err = 1'b1;
            tx_load = 1'b1;
            tx_val  = PING_BYTE;
          end
          default: fsm_err = 1'b1;
        endcase
      end
    end
  end

  assign ovw_err = tx_load && tx_valid && !tx_ack;

  always_ff @(posedge CLK_USB or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      reg_addr  <= 4'h0;
      reg_wdata <= 8'h00;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      reg_wr    <= wr_d;
      reg_rd    <= rd_d;
      reg_addr  <= addr_d;
      reg_wdata <= wdata_d;
      if (tx_load) begin
        tx_data  <= tx_val;
        tx_valid <= 1'b1;
      end else if (tx_ack) begin
        tx_valid <= 1'b0;
      end
    end
  end

  usb_sat_counter u_err_cnt (
    .CLK_USB (CLK_USB),
    .RSTn    (RSTn),
    .inc     (fsm_err || ovw_err),
    .count   (err_count)
  );

endmodule

// File: tb/tb_usb_cmd_decoder.sv
// Directed self-checking bench for usb_cmd_decoder; inputs change on the
// falling edge and outputs are sampled on the falling edge.
module tb_usb_cmd_decoder;

  localparam int TIMEOUT = 4095;

  logic       CLK_USB = 1'b0;
  logic       RSTn;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       reg_wr;
  logic       reg_rd;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ack;
  logic [7:0] err_count;

  int compared   = 0;
  int mismatched = 0;
  int exp_err    = 0;

  always #5 CLK_USB = ~CLK_USB;

  usb_cmd_decoder #(.TIMEOUT(TIMEOUT), .TIMER_W(12), .PING_BYTE(8'hA5)) dut (
    .CLK_USB   (CLK_USB),
    .RSTn      (RSTn),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ack    (tx_ack),
    .err_count (err_count)
  );

  // Apply inputs for one rising edge, then return at the next falling edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic a);
    rx_valid = v;
    rx_data  = d;
    tx_ack   = a;
    @(negedge CLK_USB);
    rx_valid = 1'b0;
    tx_ack   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset;
    RSTn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ack = 1'b0; reg_rdata = 8'h00;
    repeat (2) @(negedge CLK_USB);
    compared++; if ({reg_wr, reg_rd} !== 2'b00) begin mismatched++; $display("FAIL reset_strobes: got %b want 00", {reg_wr, reg_rd}); end
    compared++; if ({reg_addr, reg_wdata} !== 12'h000) begin mismatched++; $display("FAIL reset_addr_wdata: got %h want 000", {reg_addr, reg_wdata}); end
    compared++; if ({tx_valid, tx_data} !== 9'h000) begin mismatched++; $display("FAIL reset_tx: got %h want 000", {tx_valid, tx_data}); end
    compared++; if (err_count !== 8'h00) begin mismatched++; $display("FAIL reset_err: got %h want 00", err_count); end
    RSTn = 1'b1;
    @(negedge CLK_USB);
  endtask

  task automatic test_write;
    cyc(1'b1, 8'h83, 1'b0);
    compared++; if (reg_wr !== 1'b0) begin mismatched++; $display("FAIL write_early: reg_wr got %b want 0", reg_wr); end
    cyc(1'b1, 8'h5C, 1'b0);
    compared++; if (reg_wr !== 1'b1) begin mismatched++; $display("FAIL write_strobe: reg_wr got %b want 1", reg_wr); end
    compared++; if (reg_addr !== 4'h3) begin mismatched++; $display("FAIL write_addr: got %h want 3", reg_addr); end
    compared++; if (reg_wdata !== 8'h5C) begin mismatched++; $display("FAIL write_data: got %h want 5c", reg_wdata); end
    compared++; if (err_count !== 8'(exp_err)) begin mismatched++; $display("FAIL write_err: got %0d want %0d", err_count, exp_err); end
    cyc(1'b0, 8'h00, 1'b0);
    compared++; if (reg_wr !== 1'b0) begin mismatched++; $display("FAIL write_one_cycle: reg_wr got %b want 0", reg_wr); end
  endtask

  task automatic test_read;
    reg_rdata = 8'h9E;
    cyc(1'b1, 8'hA7, 1'b0);
    compared++; if (reg_rd !== 1'b1) begin mismatched++; $display("FAIL read_strobe: reg_rd got %b want 1", reg_rd); end
    compared++; if (reg_addr !== 4'h7) begin mismatched++; $display("FAIL read_addr: got %h want 7", reg_addr); end
    compared++; if (tx_valid !== 1'b0) begin mismatched++; $display("FAIL read_tx_early: got %b want 0", tx_valid); end
    cyc(1'b0, 8'h00, 1'b0);
    compared++; if (reg_rd !== 1'b0) begin mismatched++; $display("FAIL read_one_cycle: reg_rd got %b want 0", reg_rd); end
    compared++; if ({tx_valid, tx_data} !== 9'h19E) begin mismatched++; $display("FAIL read_reply: got %h want 19e", {tx_valid, tx_data}); end
    cyc(1'b0, 8'h00, 1'b1);
    compared++; if ({tx_valid, tx_data} !== 9'h09E) begin mismatched++; $display("FAIL read_ack: got %h want 09e", {tx_valid, tx_data}); end
  endtask

  task automatic test_ping;
    cyc(1'b1, 8'hC0, 1'b0);
    compared++; if ({tx_valid, tx_data} !== 9'h1A5) begin mismatched++; $display("FAIL ping_reply: got %h want 1a5", {tx_valid, tx_data}); end
    compared++; if (err_count !== 8'(exp_err)) begin mismatched++; $display("FAIL ping_err0: got %0d want %0d", err_count, exp_err); end
    cyc(1'b1, 8'hC0, 1'b0);
    exp_err++;
    compared++; if (err_count !== 8'(exp_err)) begin mismatched++; $display("FAIL ping_overwrite_err: got %0d want %0d", err_count, exp_err); end
    cyc(1'b1, 8'hC0, 1'b1);
    compared++; if (tx_valid !== 1'b1) begin mismatched++; $display("FAIL ping_load_beats_ack: tx_valid got %b want 1", tx_valid); end
    compared++; if (err_count !== 8'(exp_err)) begin mismatched++; $display("FAIL ping_ack_no_err: got %0d want %0d", err_count, exp_err); end
    cyc(1'b0, 8'h00, 1'b1);
    compared++; if (tx_valid !== 1'b0) begin mismatched++; $display("FAIL ping_ack: tx_valid got %b want 0", tx_valid); end
  endtask

  task automatic test_bad_headers;
    cyc(1'b1, 8'h12, 1'b0);
    exp_err++;
    compared++; if (err_count !== 8'(exp_err)) begin mismatched++; $display("FAIL no_start_err: got %0d want %0d", err_count, exp_err); end
    cyc(1'b1, 8'hE0, 1'b0);
    exp_err++;
    compared++; if (err_count !== 8'(exp_err)) begin mismatched++; $display("FAIL reserved_err: got %0d want %0d", err_count, exp_err); end
    compared++; if ({reg_wr, reg_rd, tx_valid} !== 3'b000) begin mismatched++; $display("FAIL bad_no_strobes: got %b want 000", {reg_wr, reg_rd, tx_valid}); end
  endtask

  task automatic test_timeout;
    cyc(1'b1, 8'h85, 1'b0);
    idle(TIMEOUT - 1);
    compared++; if (err_count !== 8'(exp_err)) begin mismatched++; $display("FAIL timeout_early: got %0d want %0d", err_count, exp_err); end
    cyc(1'b0, 8'h00, 1'b0);
    exp_err++;
    compared++; if (err_count !== 8'(exp_err)) begin mismatched++; $display("FAIL timeout_err: got %0d want %0d", err_count, exp_err); end
    compared++; if (reg_wr !== 1'b0) begin mismatched++; $display("FAIL timeout_no_write: got %b want 0", reg_wr); end
    cyc(1'b1, 8'h85, 1'b0);
    compared++; if (reg_wr !== 1'b0) begin mismatched++; $display("FAIL timeout_idle: header written, reg_wr got %b want 0", reg_wr); end
    cyc(1'b1, 8'h11, 1'b0);
    compared++; if ({reg_wr, reg_addr, reg_wdata} !== 13'h1511) begin mismatched++; $display("FAIL after_timeout_write: got %h want 1511", {reg_wr, reg_addr, reg_wdata}); end
    cyc(1'b1, 8'h85, 1'b0);
    idle(TIMEOUT - 1);
    cyc(1'b1, 8'h3C, 1'b0);
    compared++; if ({reg_wr, reg_addr, reg_wdata} !== 13'h153C) begin mismatched++; $display("FAIL expiry_edge_write: got %h want 153c", {reg_wr, reg_addr, reg_wdata}); end
    compared++; if (err_count !== 8'(exp_err)) begin mismatched++; $display("FAIL expiry_edge_err: got %0d want %0d", err_count, exp_err); end
  endtask

  task automatic test_back_to_back;
    reg_rdata = 8'h44;
    cyc(1'b1, 8'h81, 1'b0);
    cyc(1'b1, 8'h77, 1'b0);
    compared++; if ({reg_wr, reg_addr, reg_wdata} !== 13'h1177) begin mismatched++; $display("FAIL b2b_write1: got %h want 1177", {reg_wr, reg_addr, reg_wdata}); end
    cyc(1'b1, 8'hA2, 1'b0);
    compared++; if ({reg_wr, reg_rd, reg_addr} !== 6'b01_0010) begin mismatched++; $display("FAIL b2b_read: got %b want 010010", {reg_wr, reg_rd, reg_addr}); end
    cyc(1'b1, 8'h84, 1'b0);
    compared++; if ({tx_valid, tx_data} !== 9'h144) begin mismatched++; $display("FAIL b2b_read_reply: got %h want 144", {tx_valid, tx_data}); end
    compared++; if ({reg_wr, reg_rd} !== 2'b00) begin mismatched++; $display("FAIL b2b_rdlat_strobes: got %b want 00", {reg_wr, reg_rd}); end
    cyc(1'b1, 8'h99, 1'b0);
    compared++; if ({reg_wr, reg_addr, reg_wdata} !== 13'h1499) begin mismatched++; $display("FAIL b2b_write2: got %h want 1499", {reg_wr, reg_addr, reg_wdata}); end
    compared++; if (err_count !== 8'(exp_err)) begin mismatched++; $display("FAIL b2b_err: got %0d want %0d", err_count, exp_err); end
    cyc(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_saturate;
    int n1;
    n1 = 254 - exp_err;
    for (int i = 0; i < n1; i++) cyc(1'b1, 8'h12, 1'b0);
    compared++; if (err_count !== 8'hFE) begin mismatched++; $display("FAIL sat_fe: got %h want fe", err_count); end
    cyc(1'b1, 8'h12, 1'b0);
    compared++; if (err_count !== 8'hFF) begin mismatched++; $display("FAIL sat_ff: got %h want ff", err_count); end
    for (int i = 0; i < 300 - n1 - 1; i++) cyc(1'b1, 8'h12, 1'b0);
    exp_err = 255;
    compared++; if (err_count !== 8'hFF) begin mismatched++; $display("FAIL sat_hold: got %h want ff", err_count); end
  endtask

  task automatic test_reset_mid_command;
    cyc(1'b1, 8'h85, 1'b0);
    #2 RSTn = 1'b0;
    #1;
    compared++; if ({reg_wr, reg_rd, reg_addr, reg_wdata} !== 14'h0000) begin mismatched++; $display("FAIL midrst_reg: got %h want 0000", {reg_wr, reg_rd, reg_addr, reg_wdata}); end
    compared++; if ({tx_valid, tx_data, err_count} !== 17'h00000) begin mismatched++; $display("FAIL midrst_tx_err: got %h want 00000", {tx_valid, tx_data, err_count}); end
    exp_err = 0;
    @(negedge CLK_USB);
    RSTn = 1'b1;
    cyc(1'b1, 8'hC0, 1'b0);
    compared++; if (reg_wr !== 1'b0) begin mismatched++; $display("FAIL midrst_no_write: got %b want 0", reg_wr); end
    compared++; if ({tx_valid, tx_data} !== 9'h1A5) begin mismatched++; $display("FAIL midrst_header: got %h want 1a5", {tx_valid, tx_data}); end
    compared++; if (err_count !== 8'(exp_err)) begin mismatched++; $display("FAIL midrst_err: got %0d want %0d", err_count, exp_err); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_ping();
    test_bad_headers();
    test_timeout();
    test_back_to_back();
    test_saturate();
    test_reset_mid_command();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared", compared);
    $fatal(1, "watchdog");
  end

endmodule
